// File: rtl/seg_scan_reader_if.sv
// Frame output stream of seg_scan_reader: decoded BCD digits, per-digit error
// flags and a valid/ready handshake.
interface seg_scan_reader_if #(
    parameter int DIGITS = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     err_mask;

    modport master (
        output out_valid,
        output bcd_out,
        output err_mask,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  bcd_out,
        input  err_mask,
        output out_ready
    );
endinterface

// File: rtl/seg_scan_reader.sv
// Recovers BCD digits from a scanned 7-segment bus and emits whole scan frames.
// Optional build macro SEG_IN_ACTIVE_LOW_EN: treat seg_in as active-low (common anode).
module seg_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         seg_in,
    input  logic [DIGITS-1:0]  dig_sel,
    seg_scan_reader_if.master  out_bus,
    output logic               overrun
);

    localparam int         IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] SAT = 4'(STABLE_CYC);

    typedef enum logic {HUNT, COLLECT} state_t;

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] sel_q;
    logic [6:0]        seg_eff;
    logic [3:0]        stable_cnt;
    logic              same;
    logic              sel_onehot;
    logic              capture;
    logic [IW-1:0]     cap_idx;
    logic [3:0]        cap_bcd;
    logic              cap_err;

    state_t              state;
    logic [IW-1:0]       exp_idx;
    logic [4*DIGITS-1:0] frame_bcd;
    logic [DIGITS-1:0]   frame_err;
    logic                frame_done;

`ifdef SEG_IN_ACTIVE_LOW_EN
    assign seg_eff = ~seg_q;
`else
    assign seg_eff = seg_q;
`endif

    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b0011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1110011: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    // Equality is polarity-independent, so the raw input is compared against the raw sample.
    assign same       = (seg_in == seg_q) && (dig_sel == sel_q);
    assign sel_onehot = $onehot(dig_sel);
    assign capture    = same && sel_onehot && (stable_cnt == SAT - 4'd1);
    assign {cap_err, cap_bcd} = decode_seg(seg_eff);

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) cap_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            sel_q      <= '0;
            stable_cnt <= '0;
        end else begin
            seg_q <= seg_in;
            sel_q <= dig_sel;
            if (same && sel_onehot) begin
                if (stable_cnt != SAT) stable_cnt <= stable_cnt + 4'd1;
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    // frame_bcd/frame_err are read one cycle after completion; the next capture
    // needs a fresh run and so cannot land before that read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            exp_idx    <= '0;
            frame_bcd  <= '0;
            frame_err  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (capture) begin
                if (cap_idx == '0 || (state == COLLECT && cap_idx == exp_idx)) begin
                    frame_bcd[{cap_idx, 2'b00} +: 4] <= cap_bcd;
                    frame_err[cap_idx]               <= cap_err;
                    if (int'(cap_idx) == DIGITS - 1) begin
                        state      <= HUNT;
                        frame_done <= 1'b1;
                    end else begin
                        state   <= COLLECT;
                        exp_idx <= cap_idx + 1'b1;
                    end
                end else if (state == COLLECT) begin
                    state <= HUNT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bus.out_valid <= 1'b0;
            out_bus.bcd_out   <= '0;
            out_bus.err_mask  <= '0;
            overrun           <= 1'b0;
        end else if (frame_done) begin
            if (out_bus.out_valid && !out_bus.out_ready) begin
                overrun <= 1'b1;
            end else begin
                out_bus.out_valid <= 1'b1;
                out_bus.bcd_out   <= frame_bcd;
                out_bus.err_mask  <= frame_err;
            end
        end else if (out_bus.out_valid && out_bus.out_ready) begin
            out_bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Randomized bench for seg_scan_reader against a dwell/frame level reference model.
module tb_seg_scan_reader;

    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 3;

`ifdef SEG_IN_ACTIVE_LOW_EN
    localparam logic [6:0] INV = 7'h7F;
`else
    localparam logic [6:0] INV = 7'h00;
`endif

    localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h1F, 7'h70, 7'h7F, 7'h73};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [6:0]        seg_in;
    logic [DIGITS-1:0] dig_sel;
    logic              overrun;

    seg_scan_reader_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_in  (seg_in),
        .dig_sel (dig_sel),
        .out_bus (bus.master),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int ready_pct = 100;

    // Reference model state
    logic              m_valid, m_overrun, pend;
    logic [4*DIGITS-1:0] m_bcd, pend_bcd;
    logic [DIGITS-1:0] m_err, pend_err;
    logic [6:0]        prev_seg;
    logic [DIGITS-1:0] prev_sel;
    int                run_len;
    int                part_n;
    logic [3:0]        part_d [DIGITS];
    logic              part_e [DIGITS];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_index(input logic [DIGITS-1:0] s);
        if ($countones(s) != 1) return -1;
        for (int i = 0; i < DIGITS; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (p == PAT[i]) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_overrun = 0; pend = 0;
        m_bcd = '0; m_err = '0; pend_bcd = '0; pend_err = '0;
        prev_seg = '0; prev_sel = '0; run_len = 0; part_n = 0;
    endtask

    // One clock edge: the output stage sees last edge's completion, then the
    // dwell length of the current input decides whether a digit is captured now.
    task automatic model_edge(input logic [6:0] s, input logic [DIGITS-1:0] sel, input logic rdy);
        int k;
        logic [4:0] dec;
        if (pend) begin
            if (m_valid && !rdy) m_overrun = 1;
            else begin m_valid = 1; m_bcd = pend_bcd; m_err = pend_err; end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        pend = 0;
        if (s == prev_seg && sel == prev_sel) run_len++;
        else run_len = 1;
        prev_seg = s; prev_sel = sel;
        k = onehot_index(sel);
        if (k >= 0 && run_len == STABLE_CYC + 1) begin
            dec = ref_decode(s ^ INV);
            if (k == 0 || part_n == k) begin
                part_d[k] = dec[3:0];
                part_e[k] = dec[4];
                part_n = k + 1;
                if (part_n == DIGITS) begin
                    pend = 1;
                    for (int i = 0; i < DIGITS; i++) begin
                        pend_bcd[4*i +: 4] = part_d[i];
                        pend_err[i]        = part_e[i];
                    end
                    part_n = 0;
                end
            end else begin
                part_n = 0;
            end
        end
    endtask

    task automatic compare_all();
        checkOutput("out_valid", 32'(bus.out_valid), 32'(m_valid));
        checkOutput("bcd_out",   32'(bus.bcd_out),   32'(m_bcd));
        checkOutput("err_mask",  32'(bus.err_mask),  32'(m_err));
        checkOutput("overrun",   32'(overrun),       32'(m_overrun));
    endtask

    // Called at a falling edge: drive, step the model through the next rising edge, check.
    task automatic applyStimulus(input logic [6:0] s, input logic [DIGITS-1:0] sel, input logic rdy);
        seg_in       = s;
        dig_sel      = sel;
        bus.out_ready = rdy;
        model_edge(s, sel, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic dwell(input logic [DIGITS-1:0] sel, input logic [6:0] pat, input int len);
        for (int c = 0; c < len; c++)
            applyStimulus(pat ^ INV, sel, ($urandom_range(0, 99) < ready_pct));
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DIGITS-1:0] sel;
        logic [6:0] pat;
        int nxt, r, len;

        rst_n = 1'b0; seg_in = '0; dig_sel = '0; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Clean frame 4321
        ready_pct = 100;
        for (int d = 0; d < DIGITS; d++) dwell(DIGITS'(1) << d, PAT[(d % 9) + 1], 6);
        applyStimulus(7'h00 ^ INV, '0, 1'b1);
        checkOutput("clean_bcd", 32'(bus.bcd_out), 32'h4321);

        // Illegal pattern on digit 2, short dwell and glitch on digit 1
        dwell(4'b0001, PAT[5], 5);
        dwell(4'b0010, PAT[6], 2);
        dwell(4'b0010, 7'h01,  1);
        dwell(4'b0010, PAT[6], 4);
        dwell(4'b0100, 7'h01,  5);
        dwell(4'b1000, PAT[7], 5);
        applyStimulus(7'h00 ^ INV, '0, 1'b1);
        checkOutput("err_bcd",  32'(bus.bcd_out),  32'h7F65);
        checkOutput("err_mask_directed", 32'(bus.err_mask), 32'h4);

        // Randomized scans with moderate backpressure
        nxt = 0;
        for (int n = 0; n < 200; n++) begin
            ready_pct = (n < 100) ? 90 : 40;
            r = $urandom_range(0, 99);
            if (r < 80) begin
                sel = DIGITS'(1) << nxt; nxt = (nxt + 1) % DIGITS;
            end else if (r < 88) begin
                sel = DIGITS'(1) << $urandom_range(0, DIGITS - 1);
            end else if (r < 94) begin
                sel = DIGITS'($urandom);
            end else begin
                sel = DIGITS'(1); nxt = 1 % DIGITS;
            end
            pat = ($urandom_range(0, 99) < 88) ? PAT[$urandom_range(0, 9)] : 7'($urandom);
            len = ($urandom_range(0, 99) < 80) ? $urandom_range(STABLE_CYC + 1, STABLE_CYC + 4)
                                               : $urandom_range(1, STABLE_CYC);
            dwell(sel, pat, len);
        end

        // Reset mid-frame, orphan tail, then full rescan 6789
        ready_pct = 100;
        dwell(4'b0001, PAT[1], 5);
        dwell(4'b0010, PAT[2], 5);
        reset_pulse();
        dwell(4'b0100, PAT[3], 5);
        dwell(4'b1000, PAT[4], 5);
        dwell(4'b0001, PAT[9], 5);
        dwell(4'b0010, PAT[8], 5);
        dwell(4'b0100, PAT[7], 5);
        dwell(4'b1000, PAT[6], 5);
        applyStimulus(7'h00 ^ INV, '0, 1'b1);
        checkOutput("rescan_bcd", 32'(bus.bcd_out), 32'h6789);
        repeat (3) applyStimulus(7'h00 ^ INV, '0, 1'b1);

        // Two frames under full backpressure, then a single-cycle accept
        ready_pct = 0;
        for (int d = 0; d < DIGITS; d++) dwell(DIGITS'(1) << d, PAT[d + 1], 5);
        for (int d = 0; d < DIGITS; d++) dwell(DIGITS'(1) << d, PAT[d + 5], 5);
        applyStimulus(7'h00 ^ INV, '0, 1'b0);
        checkOutput("bp_bcd",     32'(bus.bcd_out), 32'h4321);
        checkOutput("bp_overrun", 32'(overrun),     32'h1);
        applyStimulus(7'h00 ^ INV, '0, 1'b1);
        applyStimulus(7'h00 ^ INV, '0, 1'b0);
        checkOutput("bp_valid_drop", 32'(bus.out_valid), 32'h0);

        // Heavy backpressure random phase
        reset_pulse();
        ready_pct = 5;
        nxt = 0;
        for (int n = 0; n < 100; n++) begin
            sel = DIGITS'(1) << nxt; nxt = (nxt + 1) % DIGITS;
            pat = PAT[$urandom_range(0, 9)];
            dwell(sel, pat, $urandom_range(STABLE_CYC, STABLE_CYC + 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
